// File: rtl/ahb_mem_slave.sv
// AHB-Lite slave bridging pipelined transfers onto a word-wide data memory port.
// Define AHB_MEM_SUBWORD_EN to accept byte/half transfers (writes become read-modify-write).
module ahb_mem_slave #(
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        wr_en_ram,
    output logic        rd_en_ram,
    output logic [31:0] address_ram,
    output logic [31:0] store_data,
    input  logic [31:0] read_data
);

    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ERR1   = 2'd2;
    localparam logic [1:0] ST_ERR2   = 2'd3;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

`ifdef AHB_MEM_SUBWORD_EN
    localparam logic SUBWORD_EN = 1'b1;
`else
    localparam logic SUBWORD_EN = 1'b0;
`endif

    // Replace only the addressed byte lanes of the old memory word.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [2:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] mask;
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF << {lane, 3'b000};
            SZ_HALF: mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    logic [1:0]    state_r;
    logic [3:0]    cnt_r;
    logic [AW-1:0] offset_r;
    logic          write_r;
    logic [2:0]    size_r;
    logic          hreadyout_r;
    logic          hresp_r;

    logic          final_s;
    logic          ready_s;
    logic          accept_s;
    logic          err_s;
    logic [1:0]    state_next_s;
    logic [3:0]    cnt_next_s;
    logic          hreadyout_next_s;
    logic          hresp_next_s;
    logic          unused_s;

    assign unused_s = HTRANS[0];

    assign final_s  = (state_r == ST_ACCESS) && (cnt_r == 4'd0);
    assign ready_s  = (state_r == ST_IDLE) || (state_r == ST_ERR2) || final_s;
    assign accept_s = ready_s && HSEL && HREADY && HTRANS[1];

    // Address-phase legality check.
    always_comb begin
        err_s = 1'b0;
        if (HADDR[31:AW] != '0) begin
            err_s = 1'b1;
        end else if (HSIZE > SZ_WORD) begin
            err_s = 1'b1;
        end else if ((HSIZE == SZ_HALF) && HADDR[0]) begin
            err_s = 1'b1;
        end else if ((HSIZE == SZ_WORD) && (HADDR[1:0] != 2'b00)) begin
            err_s = 1'b1;
        end else if (!SUBWORD_EN && (HSIZE != SZ_WORD)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    // Next state, wait counter and the registered bus response.
    always_comb begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
        if (accept_s) begin
            if (err_s) begin
                state_next_s = ST_ERR1;
                cnt_next_s   = 4'd0;
            end else begin
                state_next_s = ST_ACCESS;
                cnt_next_s   = WAIT_INIT;
            end
        end else begin
            case (state_r)
                ST_ACCESS: begin
                    if (cnt_r != 4'd0) begin
                        state_next_s = ST_ACCESS;
                        cnt_next_s   = cnt_r - 4'd1;
                    end else begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = 4'd0;
                    end
                end
                ST_ERR1: begin
                    state_next_s = ST_ERR2;
                    cnt_next_s   = 4'd0;
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = 4'd0;
                end
            endcase
        end
        hreadyout_next_s = !((state_next_s == ST_ERR1) ||
                             ((state_next_s == ST_ACCESS) && (cnt_next_s != 4'd0)));
        hresp_next_s     = (state_next_s == ST_ERR1) || (state_next_s == ST_ERR2);
    end

    // State, counter, captured address phase and bus response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            offset_r    <= '0;
            write_r     <= 1'b0;
            size_r      <= SZ_WORD;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            hreadyout_r <= hreadyout_next_s;
            hresp_r     <= hresp_next_s;
            if (accept_s) begin
                offset_r <= HADDR[AW-1:0];
                write_r  <= HWRITE;
                size_r   <= HSIZE;
            end else begin
                offset_r <= offset_r;
                write_r  <= write_r;
                size_r   <= size_r;
            end
        end
    end

    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;

    // Memory port and read data; the write strobe is masked by reset so a pending write is dropped.
    always_comb begin
        rd_en_ram   = 1'b0;
        wr_en_ram   = 1'b0;
        address_ram = 32'h0000_0000;
        store_data  = 32'h0000_0000;
        HRDATA      = 32'h0000_0000;
        if (state_r == ST_ACCESS) begin
            address_ram = 32'({offset_r[AW-1:2], 2'b00});
            if (write_r) begin
                rd_en_ram = final_s && (size_r != SZ_WORD);
                wr_en_ram = final_s && !rst;
                if (final_s) begin
                    store_data = merge_lanes(read_data, HWDATA, size_r, offset_r[1:0]);
                end else begin
                    store_data = 32'h0000_0000;
                end
            end else begin
                rd_en_ram = 1'b1;
                if (final_s) begin
                    HRDATA = read_data;
                end else begin
                    HRDATA = 32'h0000_0000;
                end
            end
        end else begin
            rd_en_ram = 1'b0;
        end
    end

endmodule
